// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: datapath widths, ALU opcode
// encodings and the registered ID/EX slot layout.
package id_ex_stage_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int OP_W = 6;

    // ALU opcode encodings shared with the execute stage.
    localparam logic [OP_W-1:0] ADD_OP  = 6'h01;
    localparam logic [OP_W-1:0] SUB_OP  = 6'h02;
    localparam logic [OP_W-1:0] AND_OP  = 6'h03;
    localparam logic [OP_W-1:0] OR_OP   = 6'h04;
    localparam logic [OP_W-1:0] XOR_OP  = 6'h05;
    localparam logic [OP_W-1:0] SLL_OP  = 6'h06;
    localparam logic [OP_W-1:0] SRL_OP  = 6'h07;
    localparam logic [OP_W-1:0] SRA_OP  = 6'h08;
    localparam logic [OP_W-1:0] SLT_OP  = 6'h09;
    localparam logic [OP_W-1:0] SLTU_OP = 6'h0A;

    // Everything the EX slot remembers about one instruction.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [OP_W-1:0] op;
        logic            use_imm;
        logic            use_pc;
        logic            mem_rd;
        logic            mem_wr;
        logic            reg_wr;
    } id_ex_t;

    // Turn a slot into a bubble: invalid and no side effects. Data fields are
    // left alone because nothing downstream looks at them in a bubble.
    function automatic id_ex_t kill_slot(input id_ex_t s);
        id_ex_t r;
        r        = s;
        r.valid  = 1'b0;
        r.mem_rd = 1'b0;
        r.mem_wr = 1'b0;
        r.reg_wr = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass mux: picks the youngest in-flight result for one source
// register, falling back to register-file data. x0 is never bypassed.
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [RA_W-1:0] rs_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic            exmem_reg_wr_i,
    input  logic [RA_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0] exmem_res_i,
    input  logic            memwb_reg_wr_i,
    input  logic [RA_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0] memwb_res_i,
    output logic [XLEN-1:0] fwd_o
);

    // EX/MEM is younger than MEM/WB, so it wins when both match.
    always_comb begin
        fwd_o = rf_data_i;
        if (exmem_reg_wr_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i)) begin
            fwd_o = exmem_res_i;
        end else if (memwb_reg_wr_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i)) begin
            fwd_o = memwb_res_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Captures decode fields, inserts a
// bubble on load-use hazards, and forwards/selects operands on the EX side.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic [RA_W-1:0] id_rd_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [OP_W-1:0] id_op_i,
    input  logic            id_use_imm_i,
    input  logic            id_use_pc_i,
    input  logic            id_mem_rd_i,
    input  logic            id_mem_wr_i,
    input  logic            id_reg_wr_i,
    input  logic            exmem_reg_wr_i,
    input  logic [RA_W-1:0] exmem_rd_i,
    input  logic [XLEN-1:0] exmem_res_i,
    input  logic            memwb_reg_wr_i,
    input  logic [RA_W-1:0] memwb_rd_i,
    input  logic [XLEN-1:0] memwb_res_i,
    output logic            hazard_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] opr_a_o,
    output logic [XLEN-1:0] opr_b_o,
    output logic [OP_W-1:0] op_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [RA_W-1:0] ex_rd_o,
    output logic            ex_mem_rd_o,
    output logic            ex_mem_wr_o,
    output logic            ex_reg_wr_o,
    output logic [XLEN-1:0] ex_pc_o
);

    id_ex_t          ex_d;
    id_ex_t          ex_q;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Load in EX whose destination is read by the instruction in ID. rs2 is
    // compared even for I-type; the occasional false stall is harmless.
    always_comb begin
        hazard_o = ex_q.valid && ex_q.mem_rd && (ex_q.rd != '0) && id_valid_i &&
                   ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
    end

    // Next slot contents: flush, then stall, then hazard bubble, then capture.
    always_comb begin
        // NOTE: the hold default covers every path, so no latch is inferred.
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = kill_slot(ex_q);
        end else if (stall_i) begin
            ex_d = ex_q;
        end else if (hazard_o) begin
            ex_d = kill_slot(ex_q);
        end else begin
            ex_d.valid    = id_valid_i;
            ex_d.pc       = id_pc_i;
            ex_d.rs1_data = id_rs1_data_i;
            ex_d.rs2_data = id_rs2_data_i;
            ex_d.imm      = id_imm_i;
            ex_d.rs1      = id_rs1_i;
            ex_d.rs2      = id_rs2_i;
            ex_d.rd       = id_rd_i;
            ex_d.op       = id_op_i;
            ex_d.use_imm  = id_use_imm_i;
            ex_d.use_pc   = id_use_pc_i;
            ex_d.mem_rd   = id_mem_rd_i & id_valid_i;
            ex_d.mem_wr   = id_mem_wr_i & id_valid_i;
            ex_d.reg_wr   = id_reg_wr_i & id_valid_i;
        end
    end

    // ID/EX slot register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
        if (!rst_n_i) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    fwd_mux u_fwd_rs1 (
        .rs_i           (ex_q.rs1),
        .rf_data_i      (ex_q.rs1_data),
        .exmem_reg_wr_i (exmem_reg_wr_i),
        .exmem_rd_i     (exmem_rd_i),
        .exmem_res_i    (exmem_res_i),
        .memwb_reg_wr_i (memwb_reg_wr_i),
        .memwb_rd_i     (memwb_rd_i),
        .memwb_res_i    (memwb_res_i),
        .fwd_o          (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs_i           (ex_q.rs2),
        .rf_data_i      (ex_q.rs2_data),
        .exmem_reg_wr_i (exmem_reg_wr_i),
        .exmem_rd_i     (exmem_rd_i),
        .exmem_res_i    (exmem_res_i),
        .memwb_reg_wr_i (memwb_reg_wr_i),
        .memwb_rd_i     (memwb_rd_i),
        .memwb_res_i    (memwb_res_i),
        .fwd_o          (fwd_rs2)
    );

    // ALU-ready outputs; control bits are gated so a bubble has no effect.
    always_comb begin
        ex_valid_o   = ex_q.valid;
        opr_a_o      = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
        opr_b_o      = ex_q.use_imm ? ex_q.imm : fwd_rs2;
        store_data_o = fwd_rs2;
        op_o         = ex_q.op;
        ex_rd_o      = ex_q.rd;
        ex_pc_o      = ex_q.pc;
        ex_mem_rd_o  = ex_q.mem_rd & ex_q.valid;
        ex_mem_wr_o  = ex_q.mem_wr & ex_q.valid;
        ex_reg_wr_o  = ex_q.reg_wr & ex_q.valid;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX-slot outputs are queued
// when an instruction is driven and compared once the stage presents it.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    logic            stall_i = 1'b0;
    logic            flush_i = 1'b0;
    logic            id_valid_i = 1'b0;
    logic [XLEN-1:0] id_pc_i = '0;
    logic [XLEN-1:0] id_rs1_data_i = '0;
    logic [XLEN-1:0] id_rs2_data_i = '0;
    logic [RA_W-1:0] id_rs1_i = '0;
    logic [RA_W-1:0] id_rs2_i = '0;
    logic [RA_W-1:0] id_rd_i = '0;
    logic [XLEN-1:0] id_imm_i = '0;
    logic [OP_W-1:0] id_op_i = '0;
    logic            id_use_imm_i = 1'b0;
    logic            id_use_pc_i = 1'b0;
    logic            id_mem_rd_i = 1'b0;
    logic            id_mem_wr_i = 1'b0;
    logic            id_reg_wr_i = 1'b0;
    logic            exmem_reg_wr_i = 1'b0;
    logic [RA_W-1:0] exmem_rd_i = '0;
    logic [XLEN-1:0] exmem_res_i = '0;
    logic            memwb_reg_wr_i = 1'b0;
    logic [RA_W-1:0] memwb_rd_i = '0;
    logic [XLEN-1:0] memwb_res_i = '0;
    logic            hazard_o;
    logic            ex_valid_o;
    logic [XLEN-1:0] opr_a_o;
    logic [XLEN-1:0] opr_b_o;
    logic [OP_W-1:0] op_o;
    logic [XLEN-1:0] store_data_o;
    logic [RA_W-1:0] ex_rd_o;
    logic            ex_mem_rd_o;
    logic            ex_mem_wr_o;
    logic            ex_reg_wr_o;
    logic [XLEN-1:0] ex_pc_o;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [OP_W-1:0] op;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] st;
        logic            mrd;
        logic            mwr;
        logic            rwr;
    } obs_t;

    int   total = 0;
    int   bad = 0;
    obs_t sb[$];
    obs_t exp_o;
    obs_t obs_o;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_imm_i(id_imm_i), .id_op_i(id_op_i),
        .id_use_imm_i(id_use_imm_i), .id_use_pc_i(id_use_pc_i),
        .id_mem_rd_i(id_mem_rd_i), .id_mem_wr_i(id_mem_wr_i), .id_reg_wr_i(id_reg_wr_i),
        .exmem_reg_wr_i(exmem_reg_wr_i), .exmem_rd_i(exmem_rd_i), .exmem_res_i(exmem_res_i),
        .memwb_reg_wr_i(memwb_reg_wr_i), .memwb_rd_i(memwb_rd_i), .memwb_res_i(memwb_res_i),
        .hazard_o(hazard_o), .ex_valid_o(ex_valid_o),
        .opr_a_o(opr_a_o), .opr_b_o(opr_b_o), .op_o(op_o),
        .store_data_o(store_data_o), .ex_rd_o(ex_rd_o),
        .ex_mem_rd_o(ex_mem_rd_o), .ex_mem_wr_o(ex_mem_wr_o), .ex_reg_wr_o(ex_reg_wr_o),
        .ex_pc_o(ex_pc_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input logic [OP_W-1:0] op, input logic [RA_W-1:0] rd,
                                input logic [XLEN-1:0] st, input logic mrd, input logic mwr,
                                input logic rwr);
        obs_t o;
        o.valid = v; o.a = a; o.b = b; o.op = op; o.rd = rd; o.st = st;
        o.mrd = mrd; o.mwr = mwr; o.rwr = rwr;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(ex_valid_o, opr_a_o, opr_b_o, op_o, ex_rd_o, store_data_o,
                  ex_mem_rd_o, ex_mem_wr_o, ex_reg_wr_o);
    endfunction

    // A bubble only promises valid=0 and quiet control bits.
    function automatic bit same(input obs_t o, input obs_t e);
        if (!e.valid)
            return (o.valid === 1'b0) && (o.mrd === 1'b0) && (o.mwr === 1'b0) && (o.rwr === 1'b0);
        return o === e;
    endfunction

    task automatic drive_id(input logic v, input logic [XLEN-1:0] pc,
                            input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                            input logic [RA_W-1:0] rd, input logic [XLEN-1:0] d1,
                            input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                            input logic [OP_W-1:0] op, input logic ui, input logic up,
                            input logic mrd, input logic mwr, input logic rwr);
        id_valid_i = v; id_pc_i = pc; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm; id_op_i = op;
        id_use_imm_i = ui; id_use_pc_i = up;
        id_mem_rd_i = mrd; id_mem_wr_i = mwr; id_reg_wr_i = rwr;
    endtask

    task automatic bypass(input logic ew, input logic [RA_W-1:0] erd, input logic [XLEN-1:0] eres,
                          input logic mw, input logic [RA_W-1:0] mrd, input logic [XLEN-1:0] mres);
        exmem_reg_wr_i = ew; exmem_rd_i = erd; exmem_res_i = eres;
        memwb_reg_wr_i = mw; memwb_rd_i = mrd; memwb_res_i = mres;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #12;
        exp_o = mk(0, '0, '0, '0, '0, '0, 0, 0, 0);
        obs_o = sample();
        total++;
        if (obs_o !== exp_o) begin
            bad++; $display("FAIL reset_state: got %h want %h", obs_o, exp_o);
        end
        total++;
        if (hazard_o !== 1'b0) begin
            bad++; $display("FAIL reset_hazard: got %b want 0", hazard_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic test_add();
        drive_id(1, 32'h10, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, '0, ADD_OP, 0, 0, 0, 0, 1);
        sb.push_back(mk(1, 32'd5, 32'd7, ADD_OP, 5'd3, 32'd7, 0, 0, 1));
        step();
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL add: got %h want %h", obs_o, exp_o);
        end
    endtask

    task automatic test_forward();
        drive_id(1, 32'h20, 5'd4, 5'd6, 5'd8, 32'h44, 32'h66, '0, SUB_OP, 0, 0, 0, 0, 1);
        step();
        stall_i = 1'b1;
        bypass(1, 5'd4, 32'h11, 1, 5'd4, 32'h22);
        sb.push_back(mk(1, 32'h11, 32'h66, SUB_OP, 5'd8, 32'h66, 0, 0, 1));
        #1;
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL fwd_exmem_priority: got %h want %h", obs_o, exp_o);
        end
        bypass(0, 5'd4, 32'h11, 1, 5'd4, 32'h22);
        sb.push_back(mk(1, 32'h22, 32'h66, SUB_OP, 5'd8, 32'h66, 0, 0, 1));
        #1;
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL fwd_memwb: got %h want %h", obs_o, exp_o);
        end
        bypass(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
        sb.push_back(mk(1, 32'h44, 32'h66, SUB_OP, 5'd8, 32'h66, 0, 0, 1));
        #1;
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL fwd_rd0_rf: got %h want %h", obs_o, exp_o);
        end
        bypass(0, 5'd0, '0, 1, 5'd6, 32'h77);
        sb.push_back(mk(1, 32'h44, 32'h77, SUB_OP, 5'd8, 32'h77, 0, 0, 1));
        #1;
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL fwd_rs2: got %h want %h", obs_o, exp_o);
        end
        // A register-0 source must never pick up a bypass value.
        stall_i = 1'b0;
        bypass(1, 5'd0, 32'h99, 1, 5'd0, 32'hAA);
        drive_id(1, 32'h24, 5'd0, 5'd0, 5'd9, '0, '0, '0, ADD_OP, 0, 0, 0, 0, 1);
        sb.push_back(mk(1, '0, '0, ADD_OP, 5'd9, '0, 0, 0, 1));
        step();
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL fwd_x0: got %h want %h", obs_o, exp_o);
        end
        bypass(0, '0, '0, 0, '0, '0);
    endtask

    task automatic test_load_use();
        drive_id(1, 32'h30, 5'd1, 5'd0, 5'd5, 32'h100, '0, 32'd8, ADD_OP, 1, 0, 1, 0, 1);
        sb.push_back(mk(1, 32'h100, 32'd8, ADD_OP, 5'd5, '0, 1, 0, 1));
        step();
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL lw_capture: got %h want %h", obs_o, exp_o);
        end
        drive_id(1, 32'h34, 5'd5, 5'd2, 5'd6, 32'hDEAD, 32'd7, '0, ADD_OP, 0, 0, 0, 0, 1);
        #1;
        total++;
        if (hazard_o !== 1'b1) begin
            bad++; $display("FAIL hazard_rs1: got %b want 1", hazard_o);
        end
        sb.push_back(mk(0, '0, '0, '0, '0, '0, 0, 0, 0));
        step();
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL hazard_bubble: got %h want %h", obs_o, exp_o);
        end
        total++;
        if (hazard_o !== 1'b0) begin
            bad++; $display("FAIL hazard_clear: got %b want 0", hazard_o);
        end
        // The load result now sits in MEM/WB and reaches the dependent op.
        bypass(0, '0, '0, 1, 5'd5, 32'h1234);
        sb.push_back(mk(1, 32'h1234, 32'd7, ADD_OP, 5'd6, 32'd7, 0, 0, 1));
        step();
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL dep_capture: got %h want %h", obs_o, exp_o);
        end
        bypass(0, '0, '0, 0, '0, '0);
        // rs2 is matched even though it may be unused.
        drive_id(1, 32'h38, 5'd1, 5'd0, 5'd5, '0, '0, '0, ADD_OP, 1, 0, 1, 0, 1);
        step();
        drive_id(1, 32'h3C, 5'd3, 5'd5, 5'd7, '0, '0, '0, ADD_OP, 1, 0, 0, 0, 1);
        #1;
        total++;
        if (hazard_o !== 1'b1) begin
            bad++; $display("FAIL hazard_rs2: got %b want 1", hazard_o);
        end
        // A load to x0 never stalls anything.
        drive_id(1, 32'h40, 5'd1, 5'd0, 5'd0, '0, '0, '0, ADD_OP, 1, 0, 1, 0, 1);
        step();
        drive_id(1, 32'h44, 5'd0, 5'd0, 5'd7, '0, '0, '0, ADD_OP, 0, 0, 0, 0, 1);
        #1;
        total++;
        if (hazard_o !== 1'b0) begin
            bad++; $display("FAIL hazard_x0: got %b want 0", hazard_o);
        end
    endtask

    task automatic test_stall_flush();
        drive_id(1, 32'h50, 5'd10, 5'd11, 5'd12, 32'hA, 32'hB, '0, XOR_OP, 0, 0, 0, 1, 0);
        sb.push_back(mk(1, 32'hA, 32'hB, XOR_OP, 5'd12, 32'hB, 0, 1, 0));
        step();
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL pre_stall: got %h want %h", obs_o, exp_o);
        end
        stall_i = 1'b1;
        drive_id(1, 32'h54, 5'd13, 5'd14, 5'd15, 32'hC, 32'hD, '0, OR_OP, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(1, 32'hA, 32'hB, XOR_OP, 5'd12, 32'hB, 0, 1, 0));
            step();
            exp_o = sb.pop_front(); obs_o = sample(); total++;
            if (!same(obs_o, exp_o)) begin
                bad++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs_o, exp_o);
            end
        end
        flush_i = 1'b1;
        sb.push_back(mk(0, '0, '0, '0, '0, '0, 0, 0, 0));
        step();
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL flush_over_stall: got %h want %h", obs_o, exp_o);
        end
        flush_i = 1'b0;
        stall_i = 1'b0;
    endtask

    task automatic test_imm_pc();
        bypass(0, '0, '0, 1, 5'd9, 32'h77);
        drive_id(1, 32'h100, 5'd3, 5'd9, 5'd13, 32'h33, 32'h55, 32'hFFFF_FFFC, ADD_OP, 1, 1, 0, 1, 0);
        sb.push_back(mk(1, 32'h100, 32'hFFFF_FFFC, ADD_OP, 5'd13, 32'h77, 0, 1, 0));
        step();
        exp_o = sb.pop_front(); obs_o = sample(); total++;
        if (!same(obs_o, exp_o)) begin
            bad++; $display("FAIL imm_pc_select: got %h want %h", obs_o, exp_o);
        end
        total++;
        if (ex_pc_o !== 32'h100) begin
            bad++; $display("FAIL ex_pc: got %h want 00000100", ex_pc_o);
        end
        bypass(0, '0, '0, 0, '0, '0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            logic            v, ui, up, mwr, rwr;
            logic [XLEN-1:0] pc, d1, d2, imm;
            logic [RA_W-1:0] rs1, rs2, rd;
            logic [OP_W-1:0] op;
            v = 1'($urandom); ui = 1'($urandom); up = 1'($urandom);
            mwr = 1'($urandom); rwr = 1'($urandom);
            pc = $urandom; d1 = $urandom; d2 = $urandom; imm = $urandom;
            rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
            op = 6'($urandom_range(1, 10));
            drive_id(v, pc, rs1, rs2, rd, d1, d2, imm, op, ui, up, 0, mwr, rwr);
            sb.push_back(mk(v, up ? pc : d1, ui ? imm : d2, op, rd, d2, 0, mwr & v, rwr & v));
            step();
            exp_o = sb.pop_front(); obs_o = sample(); total++;
            if (!same(obs_o, exp_o)) begin
                bad++; $display("FAIL b2b_%0d: got %h want %h", i, obs_o, exp_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_id(1, 32'h200, 5'd0, 5'd0, 5'd21, '0, '0, '0, SUB_OP, 0, 0, 1, 1, 1);
        step();
        total++;
        if (ex_valid_o !== 1'b1) begin
            bad++; $display("FAIL pre_reset_valid: got %b want 1", ex_valid_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        exp_o = mk(0, '0, '0, '0, '0, '0, 0, 0, 0);
        obs_o = sample(); total++;
        if (obs_o !== exp_o) begin
            bad++; $display("FAIL reset_mid: got %h want %h", obs_o, exp_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_load_use();
        test_stall_flush();
        test_imm_pc();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_left: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that directly feeds the execute-stage ALU.
- Captures decoded fields from the decode stage and detects load-use hazards; inserts a bubble and requests an upstream freeze when one occurs.
- On the registered side, forwards EX/MEM and MEM/WB results into the operands, then selects immediate or PC.
- Result: opr_a/opr_b/op are ALU-ready in the cycle after capture.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.
- OP_W, 6, ALU opcode width (matches the ALU op encodings in the shared defines).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- stall_i  in  1  downstream freeze; hold all registers
- flush_i  in  1  branch/exception kill; load bubble
- id_valid_i  in  1  decode slot holds a real instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
- id_rs1_i, id_rs2_i, id_rd_i  in  RA_W  register addresses
- id_imm_i  in  XLEN  sign-extended immediate
- id_op_i  in  OP_W  ALU opcode
- id_use_imm_i  in  1  opr_b = immediate
- id_use_pc_i  in  1  opr_a = PC
- id_mem_rd_i, id_mem_wr_i, id_reg_wr_i  in  1  control bits
- exmem_reg_wr_i  in  1  EX/MEM will write a register
- exmem_rd_i  in  RA_W  EX/MEM destination
- exmem_res_i  in  XLEN  EX/MEM ALU result
- memwb_reg_wr_i  in  1  MEM/WB write enable
- memwb_rd_i  in  RA_W  MEM/WB destination
- memwb_res_i  in  XLEN  MEM/WB writeback data
- hazard_o  out  1  load-use detected; freeze PC and IF/ID
- ex_valid_o  out  1  EX slot valid
- opr_a_o, opr_b_o  out  XLEN  ALU operands
- op_o  out  OP_W  ALU opcode
- store_data_o  out  XLEN  forwarded rs2 value for stores
- ex_rd_o  out  RA_W  destination
- ex_mem_rd_o, ex_mem_wr_o, ex_reg_wr_o  out  1  control bits, gated by ex_valid
- ex_pc_o  out  XLEN  registered PC

Behaviour:
- Reset (async, rst_n_i=0): all registers 0.
  - ex_valid_o=0, op_o=0, ex_rd_o=0; all control outputs 0.
  - Operands reflect zeroed registers, i.e. 0 unless forwarding matches rd=0, which is suppressed.
- Release is synchronous to clk_i.
- Load-use hazard (combinational):
  - hazard_o = ex_valid & ex_mem_rd & (ex_rd!=0) & id_valid_i & (ex_rd==id_rs1_i | ex_rd==id_rs2_i).
  - Conservative: compares rs2 even for I-type.
- Register update priority per clk_i edge, highest first:
  1. flush_i=1: ex_valid<=0 and all control bits <=0; data fields don't-care. flush_i beats stall_i.
  2. stall_i=1: hold every register unchanged.
  3. hazard_o=1: capture a bubble (ex_valid<=0, control bits <=0). The load in EX advances next cycle, which clears the hazard.
  4. Otherwise: capture all id_* fields. ex_valid<=id_valid_i; control bits gated by id_valid_i.
- Forwarding (combinational on registered rs1/rs2), per source operand:
  - If exmem_reg_wr_i & exmem_rd_i!=0 & exmem_rd_i==rs: use exmem_res_i.
  - Else if memwb_reg_wr_i & memwb_rd_i!=0 & memwb_rd_i==rs: use memwb_res_i.
  - Else use the registered RF data. EX/MEM has priority over MEM/WB; x0 is never forwarded.
- Operand selection:
  - opr_a_o = use_pc ? pc : fwd_rs1.
  - opr_b_o = use_imm ? imm : fwd_rs2.
  - store_data_o = fwd_rs2 always.
- Latency: one cycle from ID capture to valid operands.
- No arithmetic in this block; all values are passed through at XLEN width.
- When ex_valid_o=0, operand outputs are don't-care. Control outputs must be 0.
- Reset asserted mid-operation: immediate bubble; no residual forwarding state (the block holds no forwarding state).

Decomposition:
- ALU op encodings (ADD_OP, SUB_OP, …), XLEN and RA_W belong in the shared defines include; no new op codes.
- One sub-module: fwd_mux.
  - Inputs: rs address, RF data, both bypass ports.
  - Output: forwarded value.
  - Instantiated twice, for rs1 and rs2.

Test Plan:
- Reset mid-stream: assert rst_n_i low with ex_valid_o=1 → ex_valid_o, ex_reg_wr_o, ex_mem_wr_o, ex_mem_rd_o and op_o are 0 immediately, before the next edge.
- ADD x3,x1,x2 with RF x1=5, x2=7 and no bypass → the next cycle gives opr_a_o=5, opr_b_o=7, op_o=ADD_OP, ex_rd_o=3, ex_valid_o=1.
- Double forward: registered rs1=4; exmem rd=4 res=0x11; memwb rd=4 res=0x22 → opr_a_o=0x11. Drop exmem_reg_wr_i → opr_a_o=0x22. Set rd=0 on both → RF value passes.
- Load-use: EX holds LW x5 (mem_rd=1); ID has rs1=5 → hazard_o=1 that cycle. Next cycle ex_valid_o=0 and hazard_o=0; the following capture loads the dependent op.
- Stall/flush interaction: stall_i=1 for 3 cycles → outputs constant. stall_i=1 with flush_i=1 → ex_valid_o=0 next cycle.
- Immediate/PC select: use_pc=1, use_imm=1, pc=0x100, imm=0xFFFFFFFC → opr_a_o=0x100, opr_b_o=0xFFFFFFFC, and store_data_o still equals forwarded rs2.
